// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Runtime-programmable SEQ_LEN-bit serial pattern detector with
//               a same-cycle (Mealy) match flag, overlapping/non-overlapping
//               modes, an input-qualifier enable and a saturating match count.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               x,
  input  logic               load,
  input  logic [SEQ_LEN-1:0] pattern_in,
  input  logic               overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int HIST_W = SEQ_LEN - 1;
  localparam int FILL_W = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] pat;
  logic [HIST_W-1:0]  hist;
  logic [HIST_W-1:0]  hist_shift;
  logic [FILL_W-1:0]  fill;
  logic               hit;

  // History shift with the newest bit entering the LSB; a 1-bit history
  // simply takes the incoming bit.
  generate
    if (HIST_W == 1) begin : g_hist_single
      assign hist_shift = x;
    end else begin : g_hist_multi
      assign hist_shift = {hist[HIST_W-2:0], x};
    end
  endgenerate

  // Match only once a full window of real bits has been seen, so the
  // reset-zero history can never fake a match.
  always_comb begin
    hit = en & ~load & ~reset & (fill == FILL_MAX) & ({hist, x} == pat);
  end

  assign z       = hit;
  assign cnt_sat = &match_cnt;

  // Pattern, history, fill level and saturating match counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat       <= '0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (load) begin
      pat       <= pattern_in;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (en) begin
      if (hit && !overlap) begin
        // Consumed bits must not seed the next match.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_shift;
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end
      if (hit && !cnt_sat) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Scoreboard bench for seq_detector_param (SEQ_LEN=4/CNT_W=8
//               and SEQ_LEN=2/CNT_W=2 instances) driven by directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       load = 1'b0;
  logic       overlap = 1'b1;
  logic [3:0] pattern_in4 = 4'b0000;
  logic [1:0] pattern_in2 = 2'b00;

  logic       z4, sat4, z2, sat2;
  logic [7:0] cnt4;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  logic sel = 1'b0;  // 0: check 4-bit instance, 1: check 2-bit instance

  typedef struct {
    logic sel;
    logic z;
    int   cnt;
    logic sat;
  } exp_t;

  exp_t sb[$];

  seq_detector_param #(.SEQ_LEN(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in4), .overlap(overlap),
    .z(z4), .match_cnt(cnt4), .cnt_sat(sat4)
  );

  seq_detector_param #(.SEQ_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in2), .overlap(overlap),
    .z(z2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; e_cnt/e_sat are the values after this cycle's edge.
  task automatic step(input logic s_en, input logic s_x, input logic s_ld,
                      input logic s_rst, input logic e_z, input int e_cnt,
                      input logic e_sat);
    exp_t e;
    @(posedge clk);
    #1;
    en = s_en; x = s_x; load = s_ld; reset = s_rst;
    e.sel = sel; e.z = e_z; e.cnt = e_cnt; e.sat = e_sat;
    sb.push_back(e);
  endtask

  // Monitor: z checked mid-cycle, counter and saturation flag after the edge.
  initial begin
    exp_t it;
    logic a_z, a_sat;
    int   a_cnt;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        a_z = it.sel ? z2 : z4;
        checks++;
        if (a_z !== it.z) begin
          errors++;
          $display("FAIL z (sel=%0d) at %0t: got %b expected %b", it.sel, $time, a_z, it.z);
        end
        @(posedge clk);
        #1;
        a_cnt = it.sel ? int'(cnt2) : int'(cnt4);
        a_sat = it.sel ? sat2 : sat4;
        checks++;
        if (a_cnt != it.cnt) begin
          errors++;
          $display("FAIL match_cnt (sel=%0d) at %0t: got %0d expected %0d", it.sel, $time, a_cnt, it.cnt);
        end
        checks++;
        if (a_sat !== it.sat) begin
          errors++;
          $display("FAIL cnt_sat (sel=%0d) at %0t: got %b expected %b", it.sel, $time, a_sat, it.sat);
        end
      end
    end
  end

  initial begin
    int guard;
    sel = 1'b0;
    // Reset state
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Test 1: pattern 1101, overlapping
    overlap = 1'b1; pattern_in4 = 4'b1101;
    step(1, 1, 1, 0, 0, 0, 0);  // load, x discarded
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 2, 0);

    // Test 2: non-overlapping
    overlap = 1'b0;
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 2, 0);

    // Test 3: all-zero pattern after reset, no false early match
    overlap = 1'b1;
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 2, 0);
    step(1, 0, 0, 0, 1, 3, 0);

    // Test 4: enable gaps are transparent
    pattern_in4 = 4'b1101;
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);

    // Test 5a: reset mid-pattern
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);

    // Test 5b: load mid-pattern, new pattern takes effect
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);

    // Test 6: 2-bit pattern 11 with 2-bit saturating counter
    sel = 1'b1; overlap = 1'b1; pattern_in2 = 2'b11;
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 1, 2, 0);
    step(1, 1, 0, 0, 1, 3, 1);
    step(1, 1, 0, 0, 1, 3, 1);
    step(1, 1, 0, 0, 1, 3, 1);
    step(0, 1, 0, 0, 0, 3, 1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
